// File: rtl/bram_sd_sequencer.sv
// Backup-RAM save/load sequencer: walks sd_lba over one slot's sectors with one hps_io
// rd/wr handshake per sector, plus dirty-tracked autosave and clean abort on enable drop.
module bram_sd_sequencer #(
  parameter int unsigned SECT_W = 7,
  parameter int unsigned SLOT_W = 2,
  parameter int unsigned LBA_W  = 32,
  parameter int unsigned AUTO_W = 24
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [SLOT_W-1:0] slot,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              auto_en,
  input  logic [AUTO_W-1:0] auto_timeout,
  input  logic              bram_wr_mon,
  input  logic              sd_ack,
  output logic [LBA_W-1:0]  sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  output logic              busy,
  output logic              loading,
  output logic              dirty,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  state_t            state;
  logic              old_load, old_save, old_ack;
  logic [AUTO_W-1:0] auto_cnt;
  logic              load_edge, save_edge, ack_rise, ack_fall, auto_fire;
  logic [SECT_W-1:0] sect;

  assign load_edge = load_req & ~old_load;
  assign save_edge = save_req & ~old_save;
  assign ack_rise  = sd_ack & ~old_ack;
  assign ack_fall  = ~sd_ack & old_ack;
  assign sect      = sd_lba[SECT_W-1:0];
  assign auto_fire = (state == S_IDLE) & enable & dirty & auto_en &
                     (auto_timeout != '0) & (auto_cnt == auto_timeout);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      old_load <= 1'b0;
      old_save <= 1'b0;
      old_ack  <= 1'b0;
      auto_cnt <= '0;
      sd_lba   <= '0;
      sd_rd    <= 1'b0;
      sd_wr    <= 1'b0;
      busy     <= 1'b0;
      loading  <= 1'b0;
      dirty    <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      old_load <= load_req;
      old_save <= save_req;
      old_ack  <= sd_ack;
      done     <= 1'b0;
      aborted  <= 1'b0;

      if (bram_wr_mon && !loading)
        dirty <= 1'b1;

      if (bram_wr_mon || !dirty || auto_fire)
        auto_cnt <= '0;
      else if (state == S_IDLE && auto_en && auto_cnt != '1)
        auto_cnt <= auto_cnt + AUTO_W'(1);

      // Later assignments below override the dirty set above (save start, load end).
      case (state)
        S_IDLE: begin
          if (enable && load_edge) begin
            loading <= 1'b1;
            sd_rd   <= 1'b1;
            sd_lba  <= LBA_W'({slot, {SECT_W{1'b0}}});
            busy    <= 1'b1;
            state   <= S_REQ;
          end else if (enable && (save_edge || auto_fire)) begin
            sd_wr   <= 1'b1;
            dirty   <= 1'b0;
            sd_lba  <= LBA_W'({slot, {SECT_W{1'b0}}});
            busy    <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_rise) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= S_XFER;
          end
        end
        S_XFER: begin
          if (ack_fall) begin
            if ((&sect) || !enable) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              loading <= 1'b0;
              if (loading)
                dirty <= 1'b0;
              if (&sect)
                done <= 1'b1;
              else
                aborted <= 1'b1;
            end else begin
              sd_lba[SECT_W-1:0] <= sect + SECT_W'(1);
              sd_rd <= loading;
              sd_wr <= ~loading;
              state <= S_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
